day_7_map_loader: RTL

DAY_7_MAP_LOADER -- requirements
Module: day_7_map_loader

---
 rtl/day_7_map_loader_if.sv | 24 ++
 rtl/day_7_map_loader.sv | 130 +++++++++++++
 2 files changed

// File: rtl/day_7_map_loader_if.sv
// Byte-stream input and map-row write port of the day 7 map loader.
//   in_data/in_valid/in_ready : ASCII byte stream, transfer on valid & ready
//   wr_en/wr_addr/wr_data     : one-cycle row write strobe, row index, bit-row
// master = byte source / row consumer, slave = loader.
interface day_7_map_loader_if #(
  parameter int WIDTH = 141
);
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             wr_en;
  logic [7:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/day_7_map_loader.sv
// Parses the day 7 puzzle text ('.', '^', 'S', CR/LF) into splitter bit-rows.
// Each completed line of WIDTH characters is written as one row; column c
// lands on bit WIDTH-1-c. Malformed input parks the loader in ERROR.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : byte stream in, row write port out
//   start_col    : column of the 'S' character
//   start_found  : an 'S' has been seen
//   done         : all HEIGHT rows written (sticky)
//   error        : malformed input, or grid finished without 'S' (sticky)
module day_7_map_loader #(
  parameter int WIDTH  = 141,  // 2..255
  parameter int HEIGHT = 141   // 1..255
) (
  input  logic                clk,
  input  logic                rst,
  day_7_map_loader_if.slave   bus,
  output logic [7:0]          start_col,
  output logic                start_found,
  output logic                done,
  output logic                error
);

  localparam logic [7:0] CH_DOT   = 8'h2E;
  localparam logic [7:0] CH_SPLIT = 8'h5E;
  localparam logic [7:0] CH_S     = 8'h53;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  localparam logic [7:0] COL_END  = 8'(WIDTH);
  localparam logic [7:0] ROW_LAST = 8'(HEIGHT - 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_DONE  = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [7:0]       col;
  logic [7:0]       row;
  logic [WIDTH-1:0] row_buf;
  logic             wr_en_q;
  logic [7:0]       wr_addr_q;
  logic [WIDTH-1:0] wr_data_q;

  logic accept;
  logic is_cell, is_split, is_s, is_cr, is_lf;
  logic bad;

  // Byte classification and malformed-input detection.
  always_comb begin
    accept   = bus.in_valid && (state == S_LOAD);
    is_split = (bus.in_data == CH_SPLIT);
    is_s     = (bus.in_data == CH_S);
    is_cell  = (bus.in_data == CH_DOT) || is_split || is_s;
    is_cr    = (bus.in_data == CH_CR);
    is_lf    = (bus.in_data == CH_LF);
    bad      = !(is_cell || is_cr || is_lf)
             || (is_cell && (col == COL_END))
             || (is_s && start_found)
             || (is_lf && (col != COL_END));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD;
    else     state <= state_nxt;
  end

  // Next state: a good LF on the last row finishes the grid.
  always_comb begin
    state_nxt = state;
    if (state == S_LOAD && accept) begin
      if (bad)                          state_nxt = S_ERROR;
      else if (is_lf && row == ROW_LAST) state_nxt = S_DONE;
    end
  end

  // Outputs decoded from state; a grid that finishes without 'S' reports
  // error together with done.
  always_comb begin
    bus.in_ready = (state == S_LOAD);
    done         = (state == S_DONE);
    error        = (state == S_ERROR) || ((state == S_DONE) && !start_found);
  end

  // Datapath. Cells shift in from the LSB so that after WIDTH characters
  // column 0 sits at bit WIDTH-1. The write registers take a snapshot of the
  // row buffer on LF, so the buffer is free for the next row immediately.
  // Rejected bytes change nothing, which keeps the first 'S' column and
  // suppresses any write for a partial row.
  always_ff @(posedge clk) begin
    if (rst) begin
      col         <= '0;
      row         <= '0;
      row_buf     <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      start_col   <= '0;
      start_found <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (accept && !bad) begin
        if (is_cell) begin
          row_buf <= {row_buf[WIDTH-2:0], is_split};
          col     <= col + 8'd1;
          if (is_s) begin
            start_col   <= col;
            start_found <= 1'b1;
          end
        end else if (is_lf) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= row;
          wr_data_q <= row_buf;
          row_buf   <= '0;
          col       <= '0;
          row       <= row + 8'd1;
        end
      end
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule
